// File: rtl/frame_phase_scheduler.sv
// frame_phase_scheduler
// Sequences the per-frame game-logic update: on each accepted frame tick it
// strobes the enabled update engines one at a time, in index order, waiting
// for each engine's done (or a timeout) before moving on. Reports frame
// completion, engine timeouts, dropped ticks (overrun) and a frame counter.
module frame_phase_scheduler #(
  parameter int unsigned N_PHASE = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [N_PHASE-1:0] phase_mask,
  output logic [N_PHASE-1:0] phase_start,
  input  logic [N_PHASE-1:0] phase_done,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout,
  output logic [2:0]         timeout_phase,
  output logic [15:0]        frame_count
);

  localparam int unsigned     IW     = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
  localparam logic [IW-1:0]   LAST   = IW'(N_PHASE - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [TO_W-1:0]    timer;
  logic [N_PHASE-1:0] mask_lat;

  logic               phase_hit;
  logic               phase_end;
  logic               step;
  logic [N_PHASE-1:0] start_vec;

  // Decode whether the current phase finishes this cycle (done, timeout or skip)
  always_comb begin
    phase_hit = phase_done[idx];
    phase_end = (state == WAIT) && (phase_hit || (timer == TO_MAX));
    step      = phase_end || ((state == ISSUE) && !mask_lat[idx]);
    start_vec = {{(N_PHASE-1){1'b0}}, 1'b1} << idx;
  end

  // Frame sequencer with registered strobes, status pulses and frame counter
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state         <= IDLE;
      idx           <= '0;
      timer         <= '0;
      mask_lat      <= '0;
      phase_start   <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
      timeout_phase <= '0;
      frame_count   <= '0;
    end else begin
      phase_start <= '0;
      frame_done  <= 1'b0;
      timeout     <= 1'b0;
      overrun     <= frame_tick && (state != IDLE);

      case (state)
        IDLE: begin
          if (frame_tick && enable) begin
            mask_lat <= phase_mask;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mask_lat[idx]) begin
            timer       <= '0;
            phase_start <= start_vec;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (phase_end && !phase_hit) begin
            timeout       <= 1'b1;
            timeout_phase <= 3'(idx);
          end else if (!phase_end) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Skip, done and timeout share one advance path; it overrides the
      // state chosen above for ISSUE/WAIT when the current phase ends.
      if (step) begin
        if (idx == LAST) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
          state       <= DONE;
        end else begin
          idx   <= idx + 1'b1;
          state <= ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_phase_scheduler.sv
// Testbench for frame_phase_scheduler: scenarios are described as tick offsets,
// per-frame masks and per-engine reply delays; an event-level model predicts
// start strobes, timeouts, overruns, frame completions and busy time.
module tb_frame_phase_scheduler;

  localparam int NP = 4;
  localparam int TO = 5;

  logic          clk        = 1'b0;
  logic          RSTn       = 1'b0;
  logic          frame_tick = 1'b0;
  logic          enable     = 1'b0;
  logic [NP-1:0] phase_mask = '0;
  logic [NP-1:0] phase_start;
  logic [NP-1:0] phase_done;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          timeout;
  logic [2:0]    timeout_phase;
  logic [15:0]   frame_count;

  frame_phase_scheduler #(
    .N_PHASE(NP),
    .TIMEOUT(TO),
    .TO_W   (8)
  ) dut (
    .clk          (clk),
    .RSTn         (RSTn),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .phase_mask   (phase_mask),
    .phase_start  (phase_start),
    .phase_done   (phase_done),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .timeout      (timeout),
    .timeout_phase(timeout_phase),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine behaviour: reply delay per engine (-1 = never replies), plus noise
  int            dly    [NP] = '{default: 0};
  int            st_cyc [NP] = '{default: -100};
  logic [NP-1:0] stray = '0;

  always_comb begin
    phase_done = '0;
    for (int i = 0; i < NP; i++)
      phase_done[i] = stray[i] | (phase_start[i] && (dly[i] == 0)) |
                      ((dly[i] > 0) && (cyc == st_cyc[i] + dly[i]));
  end

  // Event logs observed from the DUT
  int            ev_st_c[$];
  logic [NP-1:0] ev_st_v[$];
  int            ev_fd[$];
  int            ev_to_c[$];
  logic [2:0]    ev_to_p[$];
  int            ev_ov[$];
  int            busy_total = 0;
  int            multi_err  = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NP; i++)
      if (phase_start[i]) st_cyc[i] = cyc;
    if (phase_start != '0) begin
      ev_st_c.push_back(cyc);
      ev_st_v.push_back(phase_start);
    end
    if (!$onehot0(phase_start)) multi_err++;
    if (frame_done) ev_fd.push_back(cyc);
    if (timeout) begin
      ev_to_c.push_back(cyc);
      ev_to_p.push_back(timeout_phase);
    end
    if (overrun) ev_ov.push_back(cyc);
    if (busy) busy_total++;
  end

  // Expected events, scenario description and model state
  int            exp_st_c[$];
  logic [NP-1:0] exp_st_v[$];
  int            exp_fd[$];
  int            exp_to_c[$];
  int            exp_to_p[$];
  int            exp_ov[$];
  int            win_lo[$];
  int            win_hi[$];
  int            win_ph[$];
  int            exp_busy;
  logic [15:0]   exp_cnt = '0;
  logic [2:0]    exp_tp  = '0;

  int            sc_off[$];
  logic [NP-1:0] sc_mask[$];
  int            sc_en_drop = -1;

  int total = 0;
  int bad   = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One accepted frame: walk the phases, charging 1 cycle per skip, and
  // start + reply delay + 1 (or TO + 2) cycles per enabled phase.
  task automatic model_frame(input int k, input logic [NP-1:0] m, output int td);
    int t, s, e;
    logic [NP-1:0] one;
    one = 1;
    t = k + 1;
    for (int i = 0; i < NP; i++) begin
      if (!m[i]) begin
        t++;
      end else begin
        s = t + 1;
        exp_st_c.push_back(s);
        exp_st_v.push_back(one << i);
        if (dly[i] >= 0 && dly[i] <= TO) begin
          e = s + dly[i];
          t = e + 1;
        end else begin
          e = s + TO;
          t = e + 1;
          exp_to_c.push_back(t);
          exp_to_p.push_back(i);
          exp_tp = 3'(i);
        end
        win_lo.push_back(s);
        win_hi.push_back(e);
        win_ph.push_back(i);
      end
    end
    exp_fd.push_back(t);
    td = t;
  endtask

  task automatic run_scenario(input string name);
    int base, busy_end, endc, c, td, rel, last;
    int n_st, n_fd, n_to, n_ov, b0, me0, got;
    logic tk;
    logic [NP-1:0] mk, ns;
    exp_st_c.delete(); exp_st_v.delete(); exp_fd.delete();
    exp_to_c.delete(); exp_to_p.delete(); exp_ov.delete();
    win_lo.delete(); win_hi.delete(); win_ph.delete();
    next_cycle();
    base     = cyc + 1;
    busy_end = -1;
    exp_busy = 0;
    foreach (sc_off[j]) begin
      c = base + sc_off[j];
      if (c <= busy_end) begin
        exp_ov.push_back(c + 1);
      end else if (sc_en_drop < 0 || sc_off[j] < sc_en_drop) begin
        model_frame(c, sc_mask[j], td);
        exp_busy += td - c;
        busy_end = td;
        exp_cnt  = exp_cnt + 16'd1;
      end
    end
    last = base + sc_off[sc_off.size() - 1];
    endc = ((busy_end > last) ? busy_end : last) + 4;

    n_st = ev_st_c.size(); n_fd = ev_fd.size();
    n_to = ev_to_c.size(); n_ov = ev_ov.size();
    b0 = busy_total; me0 = multi_err;

    while (cyc <= endc) begin
      rel = cyc - base;
      tk  = 1'b0;
      mk  = '0;
      foreach (sc_off[j])
        if (rel == sc_off[j]) begin
          tk = 1'b1;
          mk = sc_mask[j];
        end
      frame_tick = tk;
      phase_mask = tk ? mk : NP'($urandom);
      enable     = (sc_en_drop < 0) || (rel < sc_en_drop);
      ns = NP'($urandom);
      foreach (win_lo[w])
        if (cyc >= win_lo[w] && cyc <= win_hi[w]) ns[win_ph[w]] = 1'b0;
      stray = ns;
      next_cycle();
    end
    frame_tick = 1'b0;
    stray      = '0;
    enable     = 1'b1;
    next_cycle();

    got = ev_st_c.size() - n_st;
    total++;
    if (got !== exp_st_c.size()) begin
      bad++;
      $display("FAIL %s start_count: got %0d want %0d", name, got, exp_st_c.size());
    end else begin
      foreach (exp_st_c[i]) begin
        total++;
        if (ev_st_c[n_st+i] !== exp_st_c[i] || ev_st_v[n_st+i] !== exp_st_v[i]) begin
          bad++;
          $display("FAIL %s start[%0d]: got cyc=%0d vec=%b want cyc=%0d vec=%b", name, i,
                   ev_st_c[n_st+i], ev_st_v[n_st+i], exp_st_c[i], exp_st_v[i]);
        end
      end
    end

    got = ev_fd.size() - n_fd;
    total++;
    if (got !== exp_fd.size()) begin
      bad++;
      $display("FAIL %s frame_done_count: got %0d want %0d", name, got, exp_fd.size());
    end else begin
      foreach (exp_fd[i]) begin
        total++;
        if (ev_fd[n_fd+i] !== exp_fd[i]) begin
          bad++;
          $display("FAIL %s frame_done[%0d]: got cyc=%0d want cyc=%0d", name, i,
                   ev_fd[n_fd+i], exp_fd[i]);
        end
      end
    end

    got = ev_to_c.size() - n_to;
    total++;
    if (got !== exp_to_c.size()) begin
      bad++;
      $display("FAIL %s timeout_count: got %0d want %0d", name, got, exp_to_c.size());
    end else begin
      foreach (exp_to_c[i]) begin
        total++;
        if (ev_to_c[n_to+i] !== exp_to_c[i] || ev_to_p[n_to+i] !== 3'(exp_to_p[i])) begin
          bad++;
          $display("FAIL %s timeout[%0d]: got cyc=%0d ph=%0d want cyc=%0d ph=%0d", name, i,
                   ev_to_c[n_to+i], ev_to_p[n_to+i], exp_to_c[i], exp_to_p[i]);
        end
      end
    end

    got = ev_ov.size() - n_ov;
    total++;
    if (got !== exp_ov.size()) begin
      bad++;
      $display("FAIL %s overrun_count: got %0d want %0d", name, got, exp_ov.size());
    end else begin
      foreach (exp_ov[i]) begin
        total++;
        if (ev_ov[n_ov+i] !== exp_ov[i]) begin
          bad++;
          $display("FAIL %s overrun[%0d]: got cyc=%0d want cyc=%0d", name, i,
                   ev_ov[n_ov+i], exp_ov[i]);
        end
      end
    end

    total++;
    if (busy_total - b0 !== exp_busy) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_total - b0, exp_busy);
    end
    total++;
    if (multi_err !== me0) begin
      bad++;
      $display("FAIL %s start_onehot: got %0d bad cycles want 0", name, multi_err - me0);
    end
    total++;
    if (frame_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s frame_count: got %h want %h", name, frame_count, exp_cnt);
    end
    total++;
    if (timeout_phase !== exp_tp) begin
      bad++;
      $display("FAIL %s timeout_phase: got %0d want %0d", name, timeout_phase, exp_tp);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) next_cycle();
    total++;
    if ({phase_start, busy, frame_done, overrun, timeout, timeout_phase, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got start=%b busy=%b fd=%b ov=%b to=%b tp=%0d cnt=%h want all 0",
               phase_start, busy, frame_done, overrun, timeout, timeout_phase, frame_count);
    end
    RSTn   = 1'b1;
    enable = 1'b1;
    next_cycle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_latency();
    dly = '{0, 0, 0, 0};
    sc_off = '{0}; sc_mask = '{4'b1111}; sc_en_drop = -1;
    run_scenario("latency");
  endtask

  task automatic test_skip();
    dly = '{3, 3, 3, 3};
    sc_off = '{0}; sc_mask = '{4'b0101}; sc_en_drop = -1;
    run_scenario("skip");
    sc_mask = '{4'b0000};
    run_scenario("all_masked");
  endtask

  task automatic test_timeout();
    dly = '{0, -1, 0, 0};
    sc_off = '{0}; sc_mask = '{4'b1111}; sc_en_drop = -1;
    run_scenario("timeout");
    dly = '{0, TO, 0, 0};
    run_scenario("done_at_limit");
  endtask

  task automatic test_back_to_back();
    // Tick during phase 2, then ticks in the DONE cycle and the following IDLE cycle
    dly = '{2, 2, 2, 2};
    sc_off = '{0, 11, 17, 18};
    sc_mask = '{4'b1111, 4'b1111, 4'b1111, 4'b1011};
    sc_en_drop = -1;
    run_scenario("back_to_back");
  endtask

  task automatic test_enable();
    dly = '{0, 1, 0, 2};
    sc_off = '{0, 15}; sc_mask = '{4'b1111, 4'b1111}; sc_en_drop = 3;
    run_scenario("enable_drop");
  endtask

  task automatic test_random();
    int o;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NP; i++) begin
        o = $urandom_range(0, 6);
        dly[i] = (o == 6) ? -1 : o;
      end
      sc_off.delete(); sc_mask.delete();
      o = 0;
      for (int j = 0; j < 3; j++) begin
        sc_off.push_back(o);
        sc_mask.push_back(NP'($urandom));
        o += $urandom_range(1, 30);
      end
      sc_en_drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      run_scenario("random");
    end
  endtask

  task automatic test_wrap();
    next_cycle();
    force dut.frame_count = 16'hFFFF;
    next_cycle();
    release dut.frame_count;
    next_cycle();
    exp_cnt = 16'hFFFF;
    total++;
    if (frame_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff", frame_count);
    end
    dly = '{1, 0, 0, 0};
    sc_off = '{0}; sc_mask = '{4'b1001}; sc_en_drop = -1;
    run_scenario("wrap");
  endtask

  task automatic test_reset_mid_frame();
    int n_st, n_fd;
    dly = '{-1, -1, -1, -1};
    enable     = 1'b1;
    phase_mask = 4'b1111;
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    repeat (4) next_cycle();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_busy_before: got %b want 1", busy);
    end
    #2;
    RSTn = 1'b0;
    n_st = ev_st_c.size();
    n_fd = ev_fd.size();
    #1;
    total++;
    if ({phase_start, busy, frame_done, overrun, timeout, timeout_phase, frame_count} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got start=%b busy=%b fd=%b ov=%b to=%b tp=%0d cnt=%h want all 0",
               phase_start, busy, frame_done, overrun, timeout, timeout_phase, frame_count);
    end
    repeat (3) next_cycle();
    RSTn = 1'b1;
    repeat (20) next_cycle();
    exp_cnt = '0;
    exp_tp  = '0;
    total++;
    if (ev_fd.size() !== n_fd || ev_st_c.size() !== n_st || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after: got fd=%0d starts=%0d busy=%b want 0 0 0",
               ev_fd.size() - n_fd, ev_st_c.size() - n_st, busy);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_skip();
    test_timeout();
    test_back_to_back();
    test_enable();
    test_wrap();
    test_random();
    test_reset_mid_frame();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
